// File: rtl/assoc_cache.sv
// assoc_cache: two-way set-associative write-back / write-allocate cache
// between a 32-bit processor port and a 128-bit block memory.
// Optional feature macro: CACHE_WRITE_EN. When it is defined, the build adds
// dirty bits, write hits and the write-back state. When it is undefined, the
// build is a read-only instruction cache.
module assoc_cache #(
    parameter int ADDR_W   = 30,
    parameter int SET_BITS = 2
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [31:0]       proc_wdata,
    output logic [31:0]       proc_rdata,
    output logic              proc_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [127:0]      mem_wdata,
    input  logic [127:0]      mem_rdata,
    input  logic              mem_ready
);
    localparam int SETS  = 1 << SET_BITS;
    localparam int TAG_W = ADDR_W - SET_BITS - 2;

    typedef enum logic [1:0] {COMP, WB, ALLC} state_t;

    state_t state, state_n;

    logic             valid [SETS][2];
    logic [TAG_W-1:0] tag_q [SETS][2];
    logic [127:0]     data  [SETS][2];
    logic             lru   [SETS];    // names the older way of the set

    logic [SET_BITS-1:0] set;
    logic [TAG_W-1:0]    tag;
    logic [1:0]          word;
    logic                wr, req, hit, hit_way, victim, victim_dirty, fill;
    logic [1:0]          match;
    logic                ready_r;
    logic [127:0]        rdata_r;

    assign set  = proc_addr[SET_BITS+1:2];
    assign tag  = proc_addr[ADDR_W-1:SET_BITS+2];
    assign word = proc_addr[1:0];

`ifdef CACHE_WRITE_EN
    logic dirty [SETS][2];
    assign wr           = proc_write;
    assign victim_dirty = valid[set][victim] & dirty[set][victim];
`else
    // Writes are not serviced in the read-only build.
    logic unused_wr;
    assign unused_wr    = ^{proc_write, proc_wdata};
    assign wr           = 1'b0;
    assign victim_dirty = 1'b0;
`endif

    assign req      = proc_read | wr;
    assign match[0] = valid[set][0] && (tag_q[set][0] == tag);
    assign match[1] = valid[set][1] && (tag_q[set][1] == tag);
    assign hit      = |match;
    assign hit_way  = match[1];
    // First invalid way (way 0 first), otherwise the LRU way.
    assign victim   = !valid[set][0] ? 1'b0 : (!valid[set][1] ? 1'b1 : lru[set]);

    assign proc_rdata = data[set][hit_way][{word, 5'b0} +: 32];
    assign proc_stall = req & ~hit;

    // Register the memory response once; all FSM decisions use the registered copy.
    always_ff @(posedge clk) begin
        ready_r <= proc_reset ? 1'b0 : mem_ready;
        rdata_r <= mem_rdata;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (proc_reset) state <= COMP;
        else            state <= state_n;
    end

    // Next state and memory-side outputs.
    always_comb begin
        state_n   = state;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = proc_addr[ADDR_W-1:2];
        mem_wdata = '0;
        fill      = 1'b0;
        case (state)
            COMP: begin
                if (req && !hit) state_n = victim_dirty ? WB : ALLC;
            end
`ifdef CACHE_WRITE_EN
            WB: begin
                mem_write = !ready_r;
                mem_addr  = {tag_q[set][victim], set};
                mem_wdata = data[set][victim];
                if (ready_r) state_n = ALLC;
            end
`endif
            ALLC: begin
                mem_read = !ready_r;
                if (ready_r) begin
                    fill    = 1'b1;
                    state_n = COMP;
                end
            end
            default: state_n = COMP;
        endcase
        // Reset drops any in-flight memory request in the same cycle.
        if (proc_reset) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            fill      = 1'b0;
        end
    end

    // Line storage: fills, LRU touches and write hits.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            for (int i = 0; i < SETS; i++) begin
                valid[i][0] <= 1'b0;
                valid[i][1] <= 1'b0;
                lru[i]      <= 1'b0;
`ifdef CACHE_WRITE_EN
                dirty[i][0] <= 1'b0;
                dirty[i][1] <= 1'b0;
`endif
            end
        end else if (fill) begin
            valid[set][victim] <= 1'b1;
            tag_q[set][victim] <= tag;
            data[set][victim]  <= rdata_r;
            lru[set]           <= ~victim;
`ifdef CACHE_WRITE_EN
            dirty[set][victim] <= 1'b0;
`endif
        end else if (state == COMP && req && hit) begin
            lru[set] <= ~hit_way;
`ifdef CACHE_WRITE_EN
            if (wr) begin
                data[set][hit_way][{word, 5'b0} +: 32] <= proc_wdata;
                dirty[set][hit_way]                    <= 1'b1;
            end
`endif
        end
    end
endmodule
